mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator between the multicycle datapath and the word-only data memory port. Accepts one byte, halfword or word load/store per handshake. Issues aligned word reads and writes, using read-modify-write for sub-word stores. Returns loaded data extracted by byte lane and sign- or zero-extended. Little-endian byte lanes: the byte at addr[1:0]=0 occupies bits 7:0.

## Interface
- W, default 32 (`WORD_WIDTH), datapath and address width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE with rst high
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_signed  in  1  loads only: sign-extend when 1, zero-extend when 0
- req_addr  in  W  byte address
- req_wdata  in  W  store data; the value occupies the low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  W  load result; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid; misaligned access
- mem_read_en  out  1  memory read strobe
- mem_read_addr  out  W  word-aligned read address
- mem_read_data  in  W  memory returns this combinationally in the same cycle
- mem_write_en  out  1  memory write strobe, committed at clock edge
- mem_write_addr  out  W  word-aligned write address
- mem_write_data  out  W  full word to write

## Operation
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch we/size/signed/addr/wdata.
    - Misaligned request -> RESP.
    - Word store -> WR.
    - All other requests -> RD.
  - RD: mem_read_en=1, mem_read_addr={addr[W-1:2],2'b00}. At the clock edge, sample mem_read_data.
    - Load: latch extracted and extended value into resp_rdata, -> RESP.
    - Sub-word store: latch the merged word, -> WR.
  - WR: mem_write_en=1, mem_write_addr is the aligned address.
    - Word store writes wdata.
    - Sub-word store writes the read word with only the target lane(s) replaced by wdata[7:0] or wdata[15:0].
    - -> RESP.
  - RESP: resp_valid=1 for one cycle, -> IDLE.
- Lane select:
  - Byte: addr[1:0] selects bits [8k+7:8k].
  - Halfword: addr[1] selects [15:0] or [31:16].
- Extension: replicate the selected MSB when signed, else zeros.
- Reserved size 11 is treated as word.
- mem_*_addr and mem_write_data are 0 whenever their strobe is low. Never assert both strobes in one cycle.
- resp_rdata and resp_err hold their value until the next RESP.

## Timing
- Cycle 0 = request accepted in IDLE.
- Latency from cycle 0:
  - Load: RD at 1, resp_valid at 2.
  - Word store: WR at 1, resp_valid at 2.
  - Sub-word store: RD at 1, WR at 2, resp_valid at 3.
  - Error: resp_valid with resp_err=1 at 1; no memory strobes.
- Back-to-back: the next request can be accepted in the cycle after RESP. Throughput is 1 per 3 cycles (load) or 1 per 4 cycles (sub-word store).
- req_valid is ignored outside IDLE. The requester must hold its request until req_ready is seen.
- Reset (rst low, any state):
  - State -> IDLE.
  - Outputs immediately: req_ready=0, strobes=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - An in-flight operation is aborted: no write is issued and no response is produced.
  - req_ready rises in the first cycle with rst high.

## Configuration
- MISALIGN_TRAP_EN defined:
  - These requests complete with resp_err=1 and touch no memory: halfword with addr[0]=1, word with addr[1:0]≠00, and size 11.
- MISALIGN_TRAP_EN undefined:
  - resp_err is tied to 0.
  - Offending low address bits are ignored: halfword uses addr[1], word uses the aligned word.
  - Size 11 behaves as word.

## Test plan
Setup: preload mem[0x10010000]=0x8899AABB.
- lb at 0x10010001, signed=1 -> RD at cycle 1, resp_valid at cycle 2, resp_rdata=0xFFFFFFAA. Same access with lbu -> 0x000000AA.
- lh at 0x10010002, signed=1 -> 0xFFFF8899. Same access with lhu -> 0x00008899.
- sb 0x0000005A to 0x10010003 -> RD at cycle 1, WR at cycle 2 with data 0x5A99AABB, resp_valid at cycle 3. A following lw returns 0x5A99AABB.
- sw 0x12345678 to 0x10010002:
  - With MISALIGN_TRAP_EN: resp_err=1 at cycle 1, no mem_write_en, the word stays 0x8899AABB.
  - Without it: writes 0x12345678 to 0x10010000.
- sh to 0x10010000; pull rst low during RD -> no mem_write_en pulse and no resp_valid, the word is unchanged, req_ready=1 in the first cycle after release.
- Two loads issued back-to-back -> the second is accepted in the cycle after the first resp_valid, and the memory strobes never overlap.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response and word-memory port bundle for mem_access_unit.
// slave = the unit's view, master = requester plus memory side.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface mem_access_unit_if #(
    parameter int W = `WORD_WIDTH
);
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [1:0]   req_size;
    logic         req_signed;
    logic [W-1:0] req_addr;
    logic [W-1:0] req_wdata;
    logic         resp_valid;
    logic [W-1:0] resp_rdata;
    logic         resp_err;
    logic         mem_read_en;
    logic [W-1:0] mem_read_addr;
    logic [W-1:0] mem_read_data;
    logic         mem_write_en;
    logic [W-1:0] mem_write_addr;
    logic [W-1:0] mem_write_data;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_read_en, mem_read_addr, mem_write_en, mem_write_addr, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_read_en, mem_read_addr, mem_write_en, mem_write_addr, mem_write_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store initiator over a word-only memory port (RMW for sub-word stores).
// Optional misalignment trapping is enabled by defining MISALIGN_TRAP_EN.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mem_access_unit #(
    parameter int W = `WORD_WIDTH
) (
    input logic            clk,
    input logic            rst,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    state_t       r_state, w_next;
    logic         r_we;
    logic [1:0]   r_size;
    logic         r_signed;
    logic [W-1:0] r_addr;
    logic [15:0]  r_wlow;
    logic [W-1:0] r_wbuf;
    logic [W-1:0] r_rdata;
    logic         r_err;

    logic         w_mis;
    logic         w_ready, w_rd_en, w_wr_en, w_resp;
    logic [7:0]   w_byte;
    logic [15:0]  w_half;
    logic [W-1:0] w_load, w_merged;

`ifdef MISALIGN_TRAP_EN
    assign w_mis = (bus.req_size == 2'b11) ||
                   (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    always_comb begin
        w_byte   = bus.mem_read_data[{r_addr[1:0], 3'b000} +: 8];
        w_half   = r_addr[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
        case (r_size)
            2'b00:   w_load = {{(W-8){r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{(W-16){r_signed & w_half[15]}}, w_half};
            default: w_load = bus.mem_read_data;
        endcase
        w_merged = bus.mem_read_data;
        if (r_size == 2'b00)
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wlow[7:0];
        else
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wlow;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_rd_en = 1'b0;
        w_wr_en = 1'b0;
        w_resp  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // state is already IDLE while in reset, so gate ready with rst
                w_ready = rst;
                if (bus.req_valid) begin
                    if (w_mis)
                        w_next = S_RESP;
                    else if (bus.req_we && bus.req_size[1])
                        w_next = S_WR;
                    else
                        w_next = S_RD;
                end
            end
            S_RD: begin
                w_rd_en = 1'b1;
                w_next  = r_we ? S_WR : S_RESP;
            end
            S_WR: begin
                w_wr_en = 1'b1;
                w_next  = S_RESP;
            end
            S_RESP: begin
                w_resp = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we     <= 1'b0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wlow   <= '0;
            r_wbuf   <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.req_valid) begin
                    r_we     <= bus.req_we;
                    r_size   <= bus.req_size;
                    r_signed <= bus.req_signed;
                    r_addr   <= bus.req_addr;
                    r_wlow   <= bus.req_wdata[15:0];
                    r_wbuf   <= bus.req_wdata;
                    if (w_mis) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                S_RD: begin
                    if (r_we)
                        r_wbuf <= w_merged;
                    else begin
                        r_rdata <= w_load;
                        r_err   <= 1'b0;
                    end
                end
                S_WR: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready      = w_ready;
    assign bus.resp_valid     = w_resp;
    assign bus.resp_rdata     = r_rdata;
    assign bus.resp_err       = r_err;
    assign bus.mem_read_en    = w_rd_en;
    assign bus.mem_read_addr  = w_rd_en ? {r_addr[W-1:2], 2'b00} : '0;
    assign bus.mem_write_en   = w_wr_en;
    assign bus.mem_write_addr = w_wr_en ? {r_addr[W-1:2], 2'b00} : '0;
    assign bus.mem_write_data = w_wr_en ? r_wbuf : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random ops vs a byte-level model.
// Honours MISALIGN_TRAP_EN the same way as the design build.
module tb_mem_access_unit;
    localparam logic [31:0] BASE = 32'h1001_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.W(32)) bus ();
    mem_access_unit #(.W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic        poke_en = 1'b0;
    logic [3:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;

    assign bus.mem_read_data = mem[bus.mem_read_addr[5:2]];

    always @(posedge clk) begin
        if (bus.mem_write_en)
            mem[bus.mem_write_addr[5:2]] <= bus.mem_write_data;
        else if (poke_en)
            mem[poke_idx] <= poke_val;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int overlap  = 0;
    int zviol    = 0;
    int cnt_wr   = 0;
    int cnt_resp = 0;

    always @(negedge clk) begin
        if (bus.mem_read_en && bus.mem_write_en) overlap++;
        if (!bus.mem_read_en && bus.mem_read_addr != 0) zviol++;
        if (!bus.mem_write_en && (bus.mem_write_addr != 0 || bus.mem_write_data != 0)) zviol++;
        if (bus.mem_write_en) cnt_wr++;
        if (bus.resp_valid) cnt_resp++;
    end

    logic [31:0] g_rdata, g_wdata;
    logic        g_err;

    // ---------------- reference model: byte-lane arithmetic ----------------
    function automatic bit m_mis(input logic [31:0] a, input logic [1:0] sz);
`ifdef MISALIGN_TRAP_EN
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sg);
        int b [4];
        int v, base;
        for (int i = 0; i < 4; i++) b[i] = int'((word >> (8 * i)) & 32'hFF);
        if (sz == 2'd0) begin
            v = b[a % 4];
            if (sg && v >= 128) v -= 256;
            return 32'(v);
        end else if (sz == 2'd1) begin
            base = (a % 4 >= 2) ? 2 : 0;
            v = b[base] + 256 * b[base + 1];
            if (sg && v >= 32768) v -= 65536;
            return 32'(v);
        end
        return word;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] word, input logic [31:0] a,
                                            input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] b [4];
        logic [31:0] r;
        int base;
        if (sz >= 2'd2) return wd;
        for (int i = 0; i < 4; i++) b[i] = (word >> (8 * i)) & 32'hFF;
        if (sz == 2'd0) begin
            b[a % 4] = wd & 32'hFF;
        end else begin
            base = (a % 4 >= 2) ? 2 : 0;
            b[base]     = wd & 32'hFF;
            b[base + 1] = (wd >> 8) & 32'hFF;
        end
        r = 0;
        for (int i = 0; i < 4; i++) r = r + (b[i] << (8 * i));
        return r;
    endfunction

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = 4'(idx);
        poke_val = val;
        @(negedge clk);
        poke_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One transaction with full timing/data/memory checks against the model.
    task automatic run_op(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input string nm);
        int idx, rd_c, wr_c, rsp_c, nwr, w;
        int e_rd, e_wr, e_rsp;
        bit mis;
        logic [31:0] e_rdata, e_word;
        idx  = int'(a[5:2]);
        mis  = m_mis(a, sz);
        e_word  = ref_mem[idx];
        e_rdata = 32'h0;
        if (mis) begin
            e_rd = -1; e_wr = -1; e_rsp = 1;
        end else if (!we) begin
            e_rd = 1; e_wr = -1; e_rsp = 2;
            e_rdata = m_load(ref_mem[idx], a, sz, sg);
        end else if (sz >= 2'd2) begin
            e_rd = -1; e_wr = 1; e_rsp = 2;
            e_word = m_store(ref_mem[idx], a, sz, wd);
        end else begin
            e_rd = 1; e_wr = 2; e_rsp = 3;
            e_word = m_store(ref_mem[idx], a, sz, wd);
        end

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (!bus.req_ready) begin
            n_fail++;
            $display("FAIL %s accept: req_ready low for %0d cycles, required 1", nm, w);
        end
        @(posedge clk);
        rd_c = -1; wr_c = -1; rsp_c = -1; nwr = 0; g_wdata = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid = 1'b0;
            if (bus.mem_read_en && rd_c < 0) rd_c = c;
            if (bus.mem_write_en) begin
                if (wr_c < 0) wr_c = c;
                nwr++;
                g_wdata = bus.mem_write_data;
            end
            if (bus.resp_valid) begin
                rsp_c = c;
                g_rdata = bus.resp_rdata;
                g_err = bus.resp_err;
                break;
            end
        end
        chk({nm, " resp_cycle"}, 32'(rsp_c), 32'(e_rsp));
        chk({nm, " rd_cycle"}, 32'(rd_c), 32'(e_rd));
        chk({nm, " wr_cycle"}, 32'(wr_c), 32'(e_wr));
        chk({nm, " wr_pulses"}, 32'(nwr), (e_wr > 0) ? 32'd1 : 32'd0);
        chk({nm, " rdata"}, g_rdata, e_rdata);
        chk({nm, " err"}, {31'h0, g_err}, {31'h0, mis});
        if (e_wr > 0) chk({nm, " wdata"}, g_wdata, e_word);
        ref_mem[idx] = e_word;
        chk({nm, " mem_word"}, mem[idx], ref_mem[idx]);
        @(negedge clk);
        chk({nm, " rdata_hold"}, bus.resp_rdata, e_rdata);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_signed = 1'b0; bus.req_addr = BASE; bus.req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset req_ready", {31'h0, bus.req_ready}, 32'h0);
        chk("reset rd_en", {31'h0, bus.mem_read_en}, 32'h0);
        chk("reset wr_en", {31'h0, bus.mem_write_en}, 32'h0);
        chk("reset resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("reset rdata", bus.resp_rdata, 32'h0);
        chk("reset err", {31'h0, bus.resp_err}, 32'h0);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("reset release ready", {31'h0, bus.req_ready}, 32'h1);
        for (int i = 0; i < 16; i++) poke(i, $urandom);
        poke(0, 32'h8899AABB);
    endtask

    task automatic test_plan();
        run_op(1'b0, 2'd0, 1'b1, BASE + 1, 32'h0, "lb");
        chk("lb value", g_rdata, 32'hFFFFFFAA);
        run_op(1'b0, 2'd0, 1'b0, BASE + 1, 32'h0, "lbu");
        chk("lbu value", g_rdata, 32'h000000AA);
        run_op(1'b0, 2'd1, 1'b1, BASE + 2, 32'h0, "lh");
        chk("lh value", g_rdata, 32'hFFFF8899);
        run_op(1'b0, 2'd1, 1'b0, BASE + 2, 32'h0, "lhu");
        chk("lhu value", g_rdata, 32'h00008899);
        run_op(1'b1, 2'd0, 1'b0, BASE + 3, 32'h0000005A, "sb");
        chk("sb write data", g_wdata, 32'h5A99AABB);
        run_op(1'b0, 2'd2, 1'b0, BASE, 32'h0, "lw_after_sb");
        chk("lw after sb", g_rdata, 32'h5A99AABB);
        poke(0, 32'h8899AABB);
        run_op(1'b1, 2'd2, 1'b0, BASE + 2, 32'h12345678, "sw_mis");
`ifdef MISALIGN_TRAP_EN
        chk("sw_mis err", {31'h0, g_err}, 32'h1);
        chk("sw_mis word", mem[0], 32'h8899AABB);
`else
        chk("sw_mis err", {31'h0, g_err}, 32'h0);
        chk("sw_mis word", mem[0], 32'h12345678);
`endif
    endtask

    task automatic test_reset_abort();
        int w0, r0, w;
        poke(0, 32'h8899AABB);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd1;
        bus.req_signed = 1'b0; bus.req_addr = BASE; bus.req_wdata = 32'h0000BEEF;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("abort in RD", {31'h0, bus.mem_read_en}, 32'h1);
        w0 = cnt_wr; r0 = cnt_resp;
        #1 rst = 1'b0;
        #1;
        chk("abort rd_en", {31'h0, bus.mem_read_en}, 32'h0);
        chk("abort ready", {31'h0, bus.req_ready}, 32'h0);
        chk("abort rdata", bus.resp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort ready after release", {31'h0, bus.req_ready}, 32'h1);
        repeat (4) @(negedge clk);
        chk("abort wr pulses", 32'(cnt_wr - w0), 32'h0);
        chk("abort resp pulses", 32'(cnt_resp - r0), 32'h0);
        chk("abort word", mem[0], 32'h8899AABB);
    endtask

    task automatic test_back_to_back();
        int k, acc2, rsp1, rsp2;
        logic [31:0] a1, a2, d1, d2;
        a1 = BASE + 32'(4 * $urandom_range(1, 15));
        a2 = BASE + 32'(4 * $urandom_range(1, 15));
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_signed = 1'b0; bus.req_addr = a1; bus.req_wdata = '0;
        chk("b2b first ready", {31'h0, bus.req_ready}, 32'h1);
        k = 0; rsp1 = -1; acc2 = -1; rsp2 = -1; d1 = '0; d2 = '0;
        while (rsp1 < 0 && k < 10) begin
            @(negedge clk);
            k++;
            if (bus.resp_valid) begin
                rsp1 = k;
                d1 = bus.resp_rdata;
                bus.req_addr = a2;
            end
        end
        while (acc2 < 0 && k < 20) begin
            @(negedge clk);
            k++;
            if (bus.req_ready) acc2 = k;
        end
        @(posedge clk);
        while (rsp2 < 0 && k < 30) begin
            @(negedge clk);
            k++;
            bus.req_valid = 1'b0;
            if (bus.resp_valid) begin
                rsp2 = k;
                d2 = bus.resp_rdata;
            end
        end
        chk("b2b resp1 cycle", 32'(rsp1), 32'd2);
        chk("b2b accept2 cycle", 32'(acc2), 32'(rsp1 + 1));
        chk("b2b resp2 cycle", 32'(rsp2), 32'(acc2 + 2));
        chk("b2b data1", d1, ref_mem[a1[5:2]]);
        chk("b2b data2", d2, ref_mem[a2[5:2]]);
    endtask

    task automatic test_random();
        logic [1:0] sz;
        for (int i = 0; i < 40; i++) begin
            sz = 2'($urandom_range(0, 3));
            run_op(1'($urandom), sz, 1'($urandom), BASE + 32'($urandom_range(0, 63)),
                   $urandom, $sformatf("rnd%0d", i));
        end
    endtask

    task automatic test_strobes();
        chk("strobe overlap", 32'(overlap), 32'h0);
        chk("idle bus zero", 32'(zviol), 32'h0);
    endtask

    initial begin
        test_reset();
        test_plan();
        test_reset_abort();
        test_back_to_back();
        test_random();
        test_strobes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule
